// File: rtl/arb_pkg.sv
// Shared definitions for the prio_arb_n arbiter family.
//   ARB_FIXED / ARB_RR : values for the RR mode parameter
//   arb_state_t        : arbiter FSM state encoding
//   clog2_min1()       : index width for N requesters, never below 1
package arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    // Smallest w >= 1 such that 2**w >= n; elaborates as a constant.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int k = 1; k < 31; k++) begin
            if ((1 << k) < n) w = k + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/prio_arb_n_if.sv
// Request/grant bundle between requesters, arbiter and consumer.
//   req        : level request vector, bit i = requester i
//   out_ready  : consumer accepts the current grant
//   out_valid  : grant on out_idx/out_onehot is valid
//   out_idx    : binary index of the granted requester
//   out_onehot : one-hot copy of out_idx, zero when not valid
//   out_any    : combinational OR of req
// master = requester/consumer side, slave = arbiter side.
interface prio_arb_n_if #(
    parameter int N = 8
) ();
    import arb_pkg::*;

    localparam int W = clog2_min1(N);

    logic [N-1:0] req;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;
    logic         out_any;

    modport master (
        output req,
        output out_ready,
        input  out_valid,
        input  out_idx,
        input  out_onehot,
        input  out_any
    );

    modport slave (
        input  req,
        input  out_ready,
        output out_valid,
        output out_idx,
        output out_onehot,
        output out_any
    );

endinterface

// File: rtl/prio_arb_n_enc.sv
// prio_enc_n: combinational wrap-around priority encoder.
// Returns the first set bit of vec searching downward from top,
// wrapping from 0 to N-1 (not to 2**W-1).
//   vec   : candidate vector
//   top   : highest-priority position, must be < N
//   idx   : selected position (0 when nothing found)
//   found : vec has at least one set bit
module prio_enc_n import arb_pkg::*; #(
    parameter int N = 8,
    parameter int W = clog2_min1(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] top,
    output logic [W-1:0] idx,
    output logic         found
);

    // Walk from the lowest priority (distance N-1 below top) up to top
    // itself so that the closest match to top is the last one written.
    always_comb begin
        int pos;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(top) - k;
            if (pos < 0) pos = pos + N;
            if (vec[pos]) begin
                idx   = pos[W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_arb_n.sv
// prio_arb_n: registered N-input priority arbiter with valid/ready output.
// Fixed mode (RR=ARB_FIXED): highest set request wins.
// Round-robin mode (RR=ARB_RR): search downward from ptr with wrap; after
// each accepted grant g, ptr becomes g-1 (N-1 for g=0) so the requester
// just served has lowest priority.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : prio_arb_n_if slave modport (req/out_ready in, grant out)
//
// state    | meaning
// ARB_IDLE | no grant presented, out_valid=0
// ARB_HOLD | grant presented and frozen until out_ready
module prio_arb_n import arb_pkg::*; #(
    parameter int N  = 8,
    parameter int RR = ARB_FIXED,
    parameter int W  = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst,
    prio_arb_n_if.slave  bus
);

    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [N-1:0] ONE  = N'(1);

    arb_state_t   r_state;
    arb_state_t   w_state_nx;
    logic [W-1:0] r_idx;
    logic [W-1:0] w_idx_nx;
    logic [N-1:0] r_onehot;
    logic [N-1:0] w_onehot_nx;
    logic [W-1:0] r_ptr;
    logic [W-1:0] w_ptr_nx;

    logic [W-1:0] w_ptr_hs;
    logic [W-1:0] w_top_load;
    logic [W-1:0] w_top_hs;
    logic [W-1:0] w_idx_load;
    logic [W-1:0] w_idx_hs;
    logic         w_found_load;
    logic         w_found_hs;

    // Pointer after a handshake on the current grant; the reload in the
    // same cycle already searches from it.
    assign w_ptr_hs   = (r_idx == '0) ? LAST : (r_idx - 1'b1);
    assign w_top_load = (RR == ARB_RR) ? r_ptr    : LAST;
    assign w_top_hs   = (RR == ARB_RR) ? w_ptr_hs : LAST;

    prio_enc_n #(.N(N), .W(W)) u_enc_load (
        .vec   (bus.req),
        .top   (w_top_load),
        .idx   (w_idx_load),
        .found (w_found_load)
    );

    prio_enc_n #(.N(N), .W(W)) u_enc_hs (
        .vec   (bus.req),
        .top   (w_top_hs),
        .idx   (w_idx_hs),
        .found (w_found_hs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ARB_IDLE;
            r_idx    <= '0;
            r_onehot <= '0;
            r_ptr    <= LAST;
        end else begin
            r_state  <= w_state_nx;
            r_idx    <= w_idx_nx;
            r_onehot <= w_onehot_nx;
            r_ptr    <= w_ptr_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_idx_nx    = r_idx;
        w_onehot_nx = r_onehot;
        w_ptr_nx    = r_ptr;
        case (r_state)
            ARB_IDLE: begin
                if (w_found_load) begin
                    w_state_nx  = ARB_HOLD;
                    w_idx_nx    = w_idx_load;
                    w_onehot_nx = ONE << w_idx_load;
                end
            end
            ARB_HOLD: begin
                if (bus.out_ready) begin
                    if (RR == ARB_RR) w_ptr_nx = w_ptr_hs;
                    if (w_found_hs) begin
                        w_idx_nx    = w_idx_hs;
                        w_onehot_nx = ONE << w_idx_hs;
                    end else begin
                        // out_idx deliberately keeps the last grant.
                        w_state_nx  = ARB_IDLE;
                        w_onehot_nx = '0;
                    end
                end
            end
            default: begin
                w_state_nx  = ARB_IDLE;
                w_onehot_nx = '0;
            end
        endcase
    end

    assign bus.out_valid  = (r_state == ARB_HOLD);
    assign bus.out_idx    = r_idx;
    assign bus.out_onehot = r_onehot;
    assign bus.out_any    = |bus.req;

endmodule

// File: tb/tb_prio_arb_n.sv
module tb_prio_arb_n;
    import arb_pkg::*;

    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    bit   chk_en = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;

    always #5 clk = ~clk;

    prio_arb_n_if #(.N(8)) if0 ();
    prio_arb_n_if #(.N(8)) if1 ();
    prio_arb_n_if #(.N(5)) if2 ();

    prio_arb_n #(.N(8), .RR(ARB_FIXED)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
    prio_arb_n #(.N(8), .RR(ARB_RR))    dut1 (.clk(clk), .rst(rst1), .bus(if1));
    prio_arb_n #(.N(5), .RR(ARB_RR))    dut2 (.clk(clk), .rst(rst2), .bus(if2));

    // Behavioural model: one grant slot per arbiter plus its rotation pointer.
    bit m_valid [3];
    int m_idx   [3];
    int m_ptr   [3];

    // Winner = set request whose priority distance is smallest. Fixed mode
    // measures distance from N-1; round-robin measures it from ptr going
    // down with wrap modulo N.
    function automatic int pick(input logic [7:0] rq, input int n, input bit rr, input int ptr);
        int best, bestd, d;
        best  = -1;
        bestd = 1000;
        for (int i = 0; i < n; i++) begin
            if (rq[i]) begin
                d = rr ? ((ptr - i + n) % n) : (n - 1 - i);
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_step(input int d, input int n, input bit rr, input logic r,
                              input logic [7:0] rq, input logic rdy);
        int g;
        if (r) begin
            m_valid[d] = 1'b0;
            m_idx[d]   = 0;
            m_ptr[d]   = n - 1;
        end else if (!m_valid[d]) begin
            if (rq != 8'h00) begin
                m_idx[d]   = pick(rq, n, rr, m_ptr[d]);
                m_valid[d] = 1'b1;
            end
        end else if (rdy) begin
            g = m_idx[d];
            if (rr) m_ptr[d] = (g == 0) ? n - 1 : g - 1;
            if (rq != 8'h00) m_idx[d] = pick(rq, n, rr, m_ptr[d]);
            else             m_valid[d] = 1'b0;
        end
    endtask

    function automatic logic [31:0] exp_oh(input int d);
        return m_valid[d] ? (32'd1 << m_idx[d]) : 32'd0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Literal check of a DUT grant that also pins the model to the same value.
    task automatic lit(input string nm, input int d, input logic act_v, input logic [31:0] act_i,
                       input bit exp_v, input int exp_i);
        chk({nm, "_valid"}, act_v, exp_v);
        chk({nm, "_idx"}, act_i, exp_i);
        chk({nm, "_model_valid"}, m_valid[d], exp_v);
        chk({nm, "_model_idx"}, m_idx[d], exp_i);
    endtask

    always @(posedge clk) begin
        model_step(0, 8, 1'b0, rst0, if0.req, if0.out_ready);
        model_step(1, 8, 1'b1, rst1, if1.req, if1.out_ready);
        model_step(2, 5, 1'b1, rst2, {3'b000, if2.req}, if2.out_ready);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("d0_valid", if0.out_valid, m_valid[0]);
            chk("d0_idx", if0.out_idx, m_idx[0]);
            chk("d0_onehot", if0.out_onehot, exp_oh(0));
            chk("d0_any", if0.out_any, |if0.req);
            chk("d1_valid", if1.out_valid, m_valid[1]);
            chk("d1_idx", if1.out_idx, m_idx[1]);
            chk("d1_onehot", if1.out_onehot, exp_oh(1));
            chk("d1_any", if1.out_any, |if1.req);
            chk("d2_valid", if2.out_valid, m_valid[2]);
            chk("d2_idx", if2.out_idx, m_idx[2]);
            chk("d2_onehot", if2.out_onehot, exp_oh(2));
            chk("d2_any", if2.out_any, |if2.req);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int exp_sweep [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int exp_sparse[4] = '{7, 0, 7, 0};
    int exp_n5a   [4] = '{4, 0, 4, 0};
    int exp_n5b   [5] = '{3, 2, 1, 0, 4};

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        if0.req = 8'hFF; if0.out_ready = 1'b0;
        if1.req = 8'hFF; if1.out_ready = 1'b0;
        if2.req = 5'h1F; if2.out_ready = 1'b0;

        // Reset held for two cycles with all requests high.
        tick();
        chk_en = 1'b1;
        tick();
        lit("rst", 0, if0.out_valid, if0.out_idx, 1'b0, 0);
        chk("rst_onehot", if0.out_onehot, 32'd0);
        chk("rst_valid_rr", if1.out_valid, 1'b0);

        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        if1.req = 8'h00; if2.req = 5'h00;
        tick();
        lit("first_grant", 0, if0.out_valid, if0.out_idx, 1'b1, 7);
        chk("first_onehot", if0.out_onehot, 32'h80);

        // Fixed priority, level requests, consumer always ready.
        if0.req = 8'b0010_0110; if0.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            lit("fixed_lvl", 0, if0.out_valid, if0.out_idx, 1'b1, 5);
            chk("fixed_onehot", if0.out_onehot, 32'h20);
        end

        // Drop to IDLE; out_idx keeps last grant.
        if0.req = 8'h00;
        tick();
        lit("fixed_drop", 0, if0.out_valid, if0.out_idx, 1'b0, 5);
        chk("fixed_drop_any", if0.out_any, 1'b0);

        // Hold stability: sticky grant while out_ready low.
        if0.out_ready = 1'b0; if0.req = 8'h04;
        tick();
        lit("hold_load", 0, if0.out_valid, if0.out_idx, 1'b1, 2);
        if0.req = 8'h80;
        for (int i = 0; i < 3; i++) begin
            tick();
            lit("hold_stable", 0, if0.out_valid, if0.out_idx, 1'b1, 2);
            chk("hold_onehot", if0.out_onehot, 32'h04);
        end
        if0.out_ready = 1'b1;
        tick();
        lit("hold_release", 0, if0.out_valid, if0.out_idx, 1'b1, 7);
        if0.req = 8'h00;
        tick();
        lit("hold_end", 0, if0.out_valid, if0.out_idx, 1'b0, 7);
        chk("hold_end_onehot", if0.out_onehot, 32'd0);

        // Round-robin full sweep, no bubbles.
        if1.req = 8'hFF; if1.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            lit("rr_sweep", 1, if1.out_valid, if1.out_idx, 1'b1, exp_sweep[i]);
        end

        // Reset coincident with a handshake: reset wins.
        rst1 = 1'b1; if1.req = 8'h81;
        tick();
        lit("rr_rst_hs", 1, if1.out_valid, if1.out_idx, 1'b0, 0);
        chk("rr_rst_onehot", if1.out_onehot, 32'd0);
        rst1 = 1'b0;

        // Round-robin sparse requests, then drop-out on a handshake.
        for (int i = 0; i < 4; i++) begin
            tick();
            lit("rr_sparse", 1, if1.out_valid, if1.out_idx, 1'b1, exp_sparse[i]);
        end
        if1.req = 8'h00;
        tick();
        chk("rr_dropout_valid", if1.out_valid, 1'b0);
        chk("rr_dropout_onehot", if1.out_onehot, 32'd0);
        if1.out_ready = 1'b0;

        // N=5 round-robin: wrap at 4, reset mid-hold restores ptr.
        if2.req = 5'b10001; if2.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            lit("n5_seq", 2, if2.out_valid, if2.out_idx, 1'b1, exp_n5a[i]);
        end
        if2.out_ready = 1'b0;
        tick();
        lit("n5_hold", 2, if2.out_valid, if2.out_idx, 1'b1, 0);
        rst2 = 1'b1;
        tick();
        lit("n5_rst", 2, if2.out_valid, if2.out_idx, 1'b0, 0);
        rst2 = 1'b0;
        tick();
        lit("n5_after_rst", 2, if2.out_valid, if2.out_idx, 1'b1, 4);
        if2.req = 5'h1F; if2.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            lit("n5_sweep", 2, if2.out_valid, if2.out_idx, 1'b1, exp_n5b[i]);
        end
        if2.req = 5'h00;
        tick();
        chk("n5_idle", if2.out_valid, 1'b0);

        tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prio_arb_n.md
# prio_arb_n

Parametrised, registered priority encoder/arbiter, the N-input successor to the fixed 8-to-3 combinational encoder. It takes a vector of level requests, selects one index by fixed (highest-index-wins) or round-robin priority, and presents it on a valid/ready output. The grant is held stable until the consumer accepts it. It sits in front of shared resources such as PE result ports and buffer banks, where several requesters compete for one consumer.

## Interface
- `N`, default 8: number of request lines; legal values N ≥ 2.
- `W`, default `max(1,$clog2(N))`: index width. Derived; not overridden.
- `RR`, default 0: 0 = fixed priority, highest index wins; 1 = round-robin.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, N: level request vector; bit i = requester i.
- `out_ready`, input, 1: consumer accepts the current grant.
- `out_valid`, output, 1: `out_idx`/`out_onehot` hold a valid grant.
- `out_idx`, output, W: binary index of the granted requester.
- `out_onehot`, output, N: one-hot copy of `out_idx`; all-zero when `out_valid`=0.
- `out_any`, output, 1: combinational `|req`, for upstream status.

## Operation
- **Reset values:** `out_valid`=0, `out_idx`=0, `out_onehot`=0, pointer `ptr`=N-1.
- **States:** IDLE (`out_valid`=0) and HOLD (`out_valid`=1).
- **IDLE:** at each edge, if `req`≠0, register the selected index, set `out_valid`=1 and go to HOLD. Otherwise stay in IDLE.
- **HOLD, `out_ready`=0:** `out_idx` and `out_onehot` are frozen. Changes on `req` are ignored, including the granted bit dropping (the grant is sticky).
- **HOLD, `out_ready`=1 (handshake):**
  - If `req`≠0 at that edge, load the next selection and stay in HOLD. There is no bubble.
  - Otherwise clear `out_valid` and `out_onehot` and go to IDLE. `out_idx` keeps its last value.
- **Fixed mode (`RR`=0):** selection is the highest set bit of `req`. `ptr` is unused and stays at N-1.
- **Round-robin mode (`RR`=1):**
  - Priority order is `ptr`, `ptr`-1, …, 0, N-1, …, `ptr`+1, with wrap at N-1 (not at 2^W).
  - On each handshake with grant g, set `ptr` = g-1, or N-1 when g=0.
  - `ptr` changes only on a handshake, never on a registered load from IDLE.
  - The selection used in the IDLE→HOLD load and in the handshake reload is computed from the `ptr` value before the edge. For the handshake reload, use the next pointer value, so the just-served requester has lowest priority.
- **Simultaneous reset and handshake:** reset wins. All outputs go to reset values and `ptr`=N-1.
- **Non-power-of-two N:** indices ≥ N are never produced.

## Timing
- Latency from `req` to grant is 1 cycle: `req` sampled at edge t gives `out_valid`=1 after edge t.
- Throughput is one grant per cycle while `out_ready`=1 and `req`≠0.
- Outputs are registered. `out_any` is the only combinational output.
- There is no combinational path from `out_ready` to `out_valid`/`out_idx` within a cycle.
- Reset applied mid-HOLD: `out_valid`=0 after the same edge, and the first grant after reset uses `ptr`=N-1.

## Structure
- **Shared package `arb_pkg`:** mode constants `ARB_FIXED`=0 and `ARB_RR`=1, and a `clog2`-floor helper function for W.
- **Sub-module `prio_enc_n`:** combinational, parameter N, inputs `vec[N-1:0]` and `top[W-1:0]`, outputs `idx[W-1:0]` and `found`. It returns the first set bit searching downward from `top` with wrap.
  - Fixed mode ties `top` to N-1.
  - RR mode instantiates it twice: once with `ptr` for the IDLE load, once with the next `ptr` for the handshake reload. Sharing one instance through a mux is also acceptable.
- The top level holds the state register, output registers and `ptr`.

## Test plan
All scenarios use N=8 unless stated.
- **Reset:** assert `rst` for 2 cycles with `req`=0xFF → `out_valid`=0, `out_idx`=0, `out_onehot`=0. First grant after release: idx 7.
- **Fixed priority, level:** `RR`=0, `req`=8'b0010_0110 held, `out_ready`=1 → idx 5 every cycle from cycle 1. `out_onehot`=8'h20.
- **Hold stability:** `out_ready`=0. `req`=0x04 for one cycle, then 0x80 → `out_idx` stays 2 until `out_ready`=1. Then idx 7 on the next cycle.
- **Round-robin sweep:** `RR`=1, `req`=0xFF, `out_ready`=1 → idx sequence 7,6,5,4,3,2,1,0,7. No bubbles.
- **Round-robin sparse and drop-out:** `RR`=1, `req`=0x81 → idx sequence 7,0,7,0. Then `req`=0 during a handshake → `out_valid`=0 on the next cycle and `out_onehot`=0.
- **Non-power-of-two N and reset mid-hold:** N=5, `RR`=1, `req`=5'b10001 → idx sequence 4,0,4. Assert `rst` while in HOLD with `out_ready`=0 → `out_valid`=0 next cycle and the next grant is idx 4.
